// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and constants for the direct-mapped data cache.
//   state_t           controller states (IDLE / FETCH / WRITE)
//   SZ_BYTE/HALF/WORD access-size encodings carried in sign_mask[2:0]
//   LED_ADDR_DEFAULT  default byte address of the memory-mapped LED register
//   merge_bytes()     byte-enable merge of a new word into an old word
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic [2:0] SZ_BYTE = 3'b001;
    localparam logic [2:0] SZ_HALF = 3'b011;
    localparam logic [2:0] SZ_WORD = 3'b111;

    localparam logic [31:0] LED_ADDR_DEFAULT = 32'h0000_2000;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_word[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dcache_dm_if.sv
// dcache_dm_if: backing-memory bus between the cache and main memory.
//   mem_req   request active (held until mem_ack)
//   mem_we    1 = write, 0 = read
//   mem_addr  word address
//   mem_wdata lane-aligned store data
//   mem_wstrb byte enables
//   mem_ack   one-cycle acknowledge from memory
//   mem_rdata read word, valid with mem_ack
// master = cache side, slave = memory side.
interface dcache_dm_if;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dcache_lsu_align.sv
// dcache_lsu_align: combinational load extraction and store lane placement.
//   ld_off/ld_mask/ld_word -> ld_data   : pick byte/half/word, sign- or zero-extend
//   st_off/st_size/st_data -> st_wdata, st_wstrb : replicate data into lanes, byte enables
// Unknown size encodings are treated as word accesses.
module dcache_lsu_align
    import dcache_pkg::*;
(
    input  logic [1:0]  ld_off,
    input  logic [3:0]  ld_mask,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data,
    input  logic [1:0]  st_off,
    input  logic [2:0]  st_size,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = ld_word[8*ld_off +: 8];
        ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_mask[2:0])
            SZ_BYTE: ld_data = ld_mask[3] ? {{24{ld_byte[7]}}, ld_byte} : {24'b0, ld_byte};
            SZ_HALF: ld_data = ld_mask[3] ? {{16{ld_half[15]}}, ld_half} : {16'b0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

    always_comb begin
        case (st_size)
            SZ_BYTE: begin
                st_wdata = {4{st_data[7:0]}};
                st_wstrb = 4'b0001 << st_off;
            end
            SZ_HALF: begin
                st_wdata = {2{st_data[15:0]}};
                st_wstrb = st_off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = st_data;
                st_wstrb = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, write-through, no-write-allocate data cache with a
// memory-mapped LED register.
//   clk, rst_n            clock, synchronous active-low reset
//   addr, write_data      CPU byte address and right-aligned store data
//   memread, memwrite     CPU load / store request (both set = store)
//   sign_mask             [3] sign-extend, [2:0] access size
//   read_data             registered load result
//   clk_stall             high while a backing access is outstanding
//   led                   low LED_W bits of the LED register
//   mem                   backing-memory bus (dcache_dm_if.master)
// Optional feature macro DCACHE_STATS_EN adds hit_count / miss_count read counters.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | accepting requests; hits and LED accesses finish here
// ST_FETCH | read miss, waiting for mem_ack to fill the line
// ST_WRITE | write-through store, waiting for mem_ack
module dcache_dm
    import dcache_pkg::*;
#(
    parameter int          LINES    = 16,
    parameter logic [31:0] LED_ADDR = LED_ADDR_DEFAULT,
    parameter int          LED_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        addr,
    input  logic [31:0]        write_data,
    input  logic               memwrite,
    input  logic               memread,
    input  logic [3:0]         sign_mask,
    output logic [31:0]        read_data,
    output logic               clk_stall,
    output logic [LED_W-1:0]   led,
    dcache_dm_if.master        mem
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    state_t state, state_nxt;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags  [LINES];
    logic [31:0]      words [LINES];

    // Request captured in IDLE so the bus stays stable while stalled.
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic [3:0]  req_mask;

    logic [LED_W-1:0] led_reg;

    logic [IDX_W-1:0] cur_idx, req_idx;
    logic [TAG_W-1:0] cur_tag, req_tag;
    logic             cur_hit, req_hit, is_led, is_load;

    logic [1:0]  ld_off;
    logic [3:0]  ld_mask;
    logic [31:0] ld_word, ld_data, st_wdata;
    logic [3:0]  st_wstrb;

    assign cur_idx = addr[2 +: IDX_W];
    assign cur_tag = addr[31 -: TAG_W];
    assign req_idx = req_addr[2 +: IDX_W];
    assign req_tag = req_addr[31 -: TAG_W];
    assign cur_hit = valid[cur_idx] && (tags[cur_idx] == cur_tag);
    assign req_hit = valid[req_idx] && (tags[req_idx] == req_tag);
    assign is_led  = (addr[31:2] == LED_ADDR[31:2]);
    assign is_load = memread && !memwrite;

    // One aligner serves both hit extraction (live request) and fill extraction
    // (captured request against the returning memory word).
    assign ld_off  = (state == ST_IDLE) ? addr[1:0] : req_addr[1:0];
    assign ld_mask = (state == ST_IDLE) ? sign_mask : req_mask;
    assign ld_word = (state == ST_IDLE) ? words[cur_idx] : mem.mem_rdata;

    dcache_lsu_align u_align (
        .ld_off   (ld_off),
        .ld_mask  (ld_mask),
        .ld_word  (ld_word),
        .ld_data  (ld_data),
        .st_off   (addr[1:0]),
        .st_size  (sign_mask[2:0]),
        .st_data  (write_data),
        .st_wdata (st_wdata),
        .st_wstrb (st_wstrb)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (memwrite && !is_led)                  state_nxt = ST_WRITE;
                else if (is_load && !is_led && !cur_hit)  state_nxt = ST_FETCH;
            end
            ST_FETCH: if (mem.mem_ack) state_nxt = ST_IDLE;
            ST_WRITE: if (mem.mem_ack) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign clk_stall     = (state != ST_IDLE);
    assign mem.mem_req   = (state != ST_IDLE);
    assign mem.mem_we    = (state == ST_WRITE);
    assign mem.mem_addr  = req_addr[31:2];
    assign mem.mem_wdata = req_wdata;
    assign mem.mem_wstrb = req_strb;
    assign led           = led_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid     <= '0;
            read_data <= '0;
            led_reg   <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_strb  <= '0;
            req_mask  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (memwrite) begin
                        if (is_led) begin
                            led_reg <= LED_W'(merge_bytes(32'(led_reg), st_wdata, st_wstrb));
                        end else begin
                            req_addr  <= addr;
                            req_wdata <= st_wdata;
                            req_strb  <= st_wstrb;
                        end
                    end else if (memread) begin
                        if (is_led) begin
                            read_data <= 32'(led_reg);
                        end else if (cur_hit) begin
                            read_data <= ld_data;
                        end else begin
                            req_addr <= addr;
                            req_mask <= sign_mask;
                        end
                    end
                end
                ST_FETCH: begin
                    if (mem.mem_ack) begin
                        read_data      <= ld_data;
                        valid[req_idx] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag/data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (rst_n && state == ST_FETCH && mem.mem_ack) begin
            tags[req_idx]  <= req_tag;
            words[req_idx] <= mem.mem_rdata;
        end else if (rst_n && state == ST_WRITE && mem.mem_ack && req_hit) begin
            words[req_idx] <= merge_bytes(words[req_idx], req_wdata, req_strb);
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == ST_IDLE && is_load && !is_led) begin
            if (cur_hit) hit_count  <= hit_count + 32'd1;
            else         miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule
